fetch_unit: RTL and testbench

Instruction-fetch stage driving the IF/ID pipeline register: owns the PC, issues word reads to a variable-latency instruction memory, and presents InstructionOut/PCPlusFourOut for the IF/ID register to sample.
- Honours the same PCSel (redirect/flush) and Stall_ID (hold) controls the IF/ID register uses, so no fetched word is lost or duplicated.
- A zero word is the bubble (NOP) value.

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// bubble value, reset PC and the output-slot record.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } slot_t;

    localparam slot_t BUBBLE = '{instr: NOP_WORD, pc4: 32'h0};

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, talks to a variable-latency instruction
// memory, and feeds the IF/ID register, honouring redirect and decode stall.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        PCSel,
    input  logic [31:0] BranchTarget,
    input  logic        Stall_ID,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic [31:0] IMemData,
    output logic [31:0] InstructionOut,
    output logic [31:0] PCPlusFourOut,
    output logic        FetchValid
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt, pc_plus4;
    slot_t        out_q, out_nxt, hold_q, hold_nxt;
    logic         vld_q, vld_nxt;
    logic         slot_free;

    assign pc_plus4  = pc + 32'd4;
    assign slot_free = !vld_q || !Stall_ID;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        out_nxt   = out_q;
        vld_nxt   = vld_q;
        hold_nxt  = hold_q;
        if (PCSel) begin
            pc_nxt   = BranchTarget & 32'hFFFF_FFFC;
            out_nxt  = BUBBLE;
            vld_nxt  = 1'b0;
            hold_nxt = BUBBLE;
            // An unanswered request is still in flight at the old address.
            state_nxt = (state != HOLD && !IMemReady) ? DISCARD : FETCH;
        end else begin
            unique case (state)
                FETCH: begin
                    if (IMemReady) begin
                        pc_nxt = pc_plus4;
                        if (slot_free) begin
                            out_nxt = '{instr: IMemData, pc4: pc_plus4};
                            vld_nxt = 1'b1;
                        end else begin
                            hold_nxt  = '{instr: IMemData, pc4: pc_plus4};
                            state_nxt = HOLD;
                        end
                    end else if (!Stall_ID) begin
                        out_nxt = BUBBLE;
                        vld_nxt = 1'b0;
                    end
                end
                HOLD: begin
                    if (!Stall_ID) begin
                        out_nxt   = hold_q;
                        vld_nxt   = 1'b1;
                        state_nxt = FETCH;
                    end
                end
                DISCARD: begin
                    if (IMemReady) state_nxt = FETCH;
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            out_q  <= BUBBLE;
            vld_q  <= 1'b0;
            hold_q <= BUBBLE;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            out_q  <= out_nxt;
            vld_q  <= vld_nxt;
            hold_q <= hold_nxt;
        end
    end

    assign IMemReq        = (state == FETCH) || (state == DISCARD);
    assign IMemAddr       = pc;
    assign InstructionOut = out_q.instr;
    assign PCPlusFourOut  = out_q.pc4;
    assign FetchValid     = vld_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-scenario tasks with hand-computed
// expectations; the memory is either zero-wait (auto) or driven by hand.
module tb_fetch_unit;

    logic        Clock = 1'b0;
    logic        Reset, PCSel, Stall_ID;
    logic [31:0] BranchTarget;
    logic        IMemReq, IMemReady, FetchValid;
    logic [31:0] IMemAddr, IMemData, InstructionOut, PCPlusFourOut;

    logic        auto_mem;
    logic        man_rdy;
    logic [31:0] man_data;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'hC0DE_0001;
    endfunction

    always #5 Clock = ~Clock;

    always_comb begin
        IMemReady = auto_mem ? IMemReq : man_rdy;
        IMemData  = auto_mem ? memw(IMemAddr) : man_data;
    end

    fetch_unit #(.RESET_PC(32'h0)) dut (
        .Clock(Clock), .Reset(Reset), .PCSel(PCSel), .BranchTarget(BranchTarget),
        .Stall_ID(Stall_ID), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .IMemReady(IMemReady), .IMemData(IMemData), .InstructionOut(InstructionOut),
        .PCPlusFourOut(PCPlusFourOut), .FetchValid(FetchValid)
    );

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0; PCSel = 1'b0; Stall_ID = 1'b0; BranchTarget = 32'h0;
        auto_mem = 1'b0; man_rdy = 1'b0; man_data = 32'h0;
        step(); step();
        checks++;
        if ({FetchValid, InstructionOut, PCPlusFourOut} !== {1'b0, 64'h0}) begin
            errors++;
            $display("FAIL reset_out got v=%b i=%h p=%h want 0/0/0", FetchValid, InstructionOut, PCPlusFourOut);
        end
        checks++;
        if ({IMemReq, IMemAddr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL reset_req got req=%b addr=%h want 1/0", IMemReq, IMemAddr);
        end
    endtask

    task automatic test_zero_wait();
        Reset = 1'b1; auto_mem = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({FetchValid, InstructionOut, PCPlusFourOut} !==
                {1'b1, memw(32'(4*k)), 32'(4*k+4)}) begin
                errors++;
                $display("FAIL zw_out%0d got v=%b i=%h p=%h want 1/%h/%h", k, FetchValid,
                         InstructionOut, PCPlusFourOut, memw(32'(4*k)), 32'(4*k+4));
            end
            checks++;
            if (IMemAddr !== 32'(4*k+4)) begin
                errors++;
                $display("FAIL zw_addr%0d got %h want %h", k, IMemAddr, 32'(4*k+4));
            end
        end
    endtask

    task automatic test_latency();
        auto_mem = 1'b0; man_rdy = 1'b0;
        Reset = 1'b0; step(); Reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if ({FetchValid, InstructionOut, PCPlusFourOut, IMemReq, IMemAddr} !==
                {1'b0, 64'h0, 1'b1, 32'h0}) begin
                errors++;
                $display("FAIL lat_wait%0d got v=%b i=%h req=%b addr=%h want 0/0/1/0", k,
                         FetchValid, InstructionOut, IMemReq, IMemAddr);
            end
        end
        man_rdy = 1'b1; man_data = memw(32'h0);
        step();
        man_rdy = 1'b0;
        checks++;
        if ({FetchValid, InstructionOut, PCPlusFourOut, IMemAddr} !==
            {1'b1, memw(32'h0), 32'h4, 32'h4}) begin
            errors++;
            $display("FAIL lat_resp got v=%b i=%h p=%h addr=%h want 1/%h/4/4", FetchValid,
                     InstructionOut, PCPlusFourOut, IMemAddr, memw(32'h0));
        end
        step();
        checks++;
        if ({FetchValid, InstructionOut, PCPlusFourOut} !== {1'b0, 64'h0}) begin
            errors++;
            $display("FAIL lat_bubble got v=%b i=%h p=%h want 0/0/0", FetchValid, InstructionOut, PCPlusFourOut);
        end
    endtask

    task automatic test_stall_hold();
        man_rdy = 1'b1; man_data = memw(32'h4);
        step();
        Stall_ID = 1'b1; man_data = memw(32'h8);
        step();
        man_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({FetchValid, InstructionOut, PCPlusFourOut, IMemReq, IMemAddr} !==
                {1'b1, memw(32'h4), 32'h8, 1'b0, 32'hC}) begin
                errors++;
                $display("FAIL hold_frozen%0d got v=%b i=%h p=%h req=%b addr=%h want 1/%h/8/0/c", k,
                         FetchValid, InstructionOut, PCPlusFourOut, IMemReq, IMemAddr, memw(32'h4));
            end
            if (k < 3) step();
        end
        Stall_ID = 1'b0;
        step();
        checks++;
        if ({FetchValid, InstructionOut, PCPlusFourOut, IMemReq, IMemAddr} !==
            {1'b1, memw(32'h8), 32'hC, 1'b1, 32'hC}) begin
            errors++;
            $display("FAIL hold_release got v=%b i=%h p=%h req=%b addr=%h want 1/%h/c/1/c",
                     FetchValid, InstructionOut, PCPlusFourOut, IMemReq, IMemAddr, memw(32'h8));
        end
        man_rdy = 1'b1; man_data = memw(32'hC);
        step();
        man_rdy = 1'b0;
        checks++;
        if ({InstructionOut, PCPlusFourOut} !== {memw(32'hC), 32'h10}) begin
            errors++;
            $display("FAIL hold_next got i=%h p=%h want %h/10", InstructionOut, PCPlusFourOut, memw(32'hC));
        end
    endtask

    task automatic test_redirect_pending();
        step();
        PCSel = 1'b1; BranchTarget = 32'h43;
        step();
        PCSel = 1'b0;
        checks++;
        if ({FetchValid, InstructionOut, PCPlusFourOut, IMemReq, IMemAddr} !==
            {1'b0, 64'h0, 1'b1, 32'h40}) begin
            errors++;
            $display("FAIL redir_discard got v=%b i=%h req=%b addr=%h want 0/0/1/40",
                     FetchValid, InstructionOut, IMemReq, IMemAddr);
        end
        man_rdy = 1'b1; man_data = memw(32'h10);
        step();
        checks++;
        if ({FetchValid, InstructionOut, IMemAddr} !== {1'b0, 32'h0, 32'h40}) begin
            errors++;
            $display("FAIL redir_stale got v=%b i=%h addr=%h want 0/0/40", FetchValid, InstructionOut, IMemAddr);
        end
        man_data = memw(32'h40);
        step();
        man_rdy = 1'b0;
        checks++;
        if ({FetchValid, InstructionOut, PCPlusFourOut} !== {1'b1, memw(32'h40), 32'h44}) begin
            errors++;
            $display("FAIL redir_target got v=%b i=%h p=%h want 1/%h/44", FetchValid,
                     InstructionOut, PCPlusFourOut, memw(32'h40));
        end
    endtask

    task automatic test_redirect_in_hold();
        Stall_ID = 1'b1; man_rdy = 1'b1; man_data = memw(32'h44);
        step();
        man_rdy = 1'b0; PCSel = 1'b1; BranchTarget = 32'h80;
        step();
        PCSel = 1'b0;
        checks++;
        if ({FetchValid, InstructionOut, PCPlusFourOut, IMemReq, IMemAddr} !==
            {1'b0, 64'h0, 1'b1, 32'h80}) begin
            errors++;
            $display("FAIL hold_redir got v=%b i=%h req=%b addr=%h want 0/0/1/80",
                     FetchValid, InstructionOut, IMemReq, IMemAddr);
        end
        Stall_ID = 1'b0; man_rdy = 1'b1; man_data = memw(32'h80);
        step();
        man_rdy = 1'b0;
        checks++;
        if ({FetchValid, InstructionOut, PCPlusFourOut} !== {1'b1, memw(32'h80), 32'h84}) begin
            errors++;
            $display("FAIL hold_redir_next got v=%b i=%h p=%h want 1/%h/84", FetchValid,
                     InstructionOut, PCPlusFourOut, memw(32'h80));
        end
    endtask

    task automatic test_reset_and_wrap();
        Stall_ID = 1'b1;
        step();
        Reset = 1'b0;
        step();
        Reset = 1'b1; Stall_ID = 1'b0;
        checks++;
        if ({FetchValid, InstructionOut, PCPlusFourOut, IMemReq, IMemAddr} !==
            {1'b0, 64'h0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL midreset got v=%b i=%h req=%b addr=%h want 0/0/1/0",
                     FetchValid, InstructionOut, IMemReq, IMemAddr);
        end
        PCSel = 1'b1; BranchTarget = 32'hFFFF_FFFC; man_rdy = 1'b1; man_data = memw(32'h0);
        step();
        PCSel = 1'b0;
        checks++;
        if ({FetchValid, IMemReq, IMemAddr} !== {1'b0, 1'b1, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL wrap_redir got v=%b req=%b addr=%h want 0/1/fffffffc", FetchValid, IMemReq, IMemAddr);
        end
        man_data = memw(32'hFFFF_FFFC);
        step();
        man_rdy = 1'b0;
        checks++;
        if ({FetchValid, InstructionOut, PCPlusFourOut, IMemAddr} !==
            {1'b1, memw(32'hFFFF_FFFC), 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL wrap got v=%b i=%h p=%h addr=%h want 1/%h/0/0", FetchValid,
                     InstructionOut, PCPlusFourOut, IMemAddr, memw(32'hFFFF_FFFC));
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall_hold();
        test_redirect_pending();
        test_redirect_in_hold();
        test_reset_and_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
